// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    // Decimal digits needed for any W-bit unsigned value, i.e. ceil(W*log10(2)).
    function automatic int unsigned min_digits(input int unsigned w);
        longint unsigned v;
        int unsigned     n;
        v = (64'd1 << w) - 64'd1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (v != 64'd0) begin
                n++;
                v = v / 64'd10;
            end
        end
        if (n == 0) begin
            n = 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One double-dabble correction step: a digit above 4 gets 3 added before the shift.
module bcd_digit_adjust (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit > 4'd4) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/seq_bin_to_bcd.sv
// Sequential double-dabble converter: W cycles per value, ready/valid on both sides,
// saturates to all nines on overflow and flags leading zeros for display blanking.
module seq_bin_to_bcd
    import bcd_pkg::*;
#(
    parameter int unsigned W      = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] bcd,
    output logic                ovf,
    output logic [DIGITS-1:0]   blank
);

    localparam int unsigned NB = 4 * DIGITS;
    localparam int unsigned CW = $clog2(W + 1);
    // With enough digits for every W-bit value the carry-out can never be set.
    localparam bit OvfPossible = (DIGITS < min_digits(W));

    state_e          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [W-1:0]    r_sr, w_sr_nxt;
    logic [NB-1:0]   r_digits, w_digits_nxt;
    logic [NB-1:0]   w_adj;
    logic            r_ovf, w_ovf_nxt;
    logic            w_accept;
    logic            w_upper_zero;
    logic [DIGITS-1:0] w_blank;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .i_digit(r_digits[4*g +: 4]),
            .o_digit(w_adj[4*g +: 4])
        );
    end

    assign in_ready = (r_state == StIdle) || ((r_state == StDone) && out_ready);
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_sr_nxt     = r_sr;
        w_digits_nxt = r_digits;
        w_ovf_nxt    = r_ovf;
        if (w_accept) begin
            w_sr_nxt     = in_data;
            w_digits_nxt = '0;
            w_ovf_nxt    = 1'b0;
            w_cnt_nxt    = CW'(W);
            w_state_nxt  = StShift;
        end else begin
            case (r_state)
                StShift: begin
                    w_digits_nxt = {w_adj[NB-2:0], r_sr[W-1]};
                    w_sr_nxt     = {r_sr[W-2:0], 1'b0};
                    w_ovf_nxt    = r_ovf | (OvfPossible & w_adj[NB-1]);
                    w_cnt_nxt    = r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        w_state_nxt = StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        w_state_nxt = StIdle;
                    end
                end
                StIdle:  w_state_nxt = StIdle;
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_sr     <= '0;
            r_digits <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sr     <= w_sr_nxt;
            r_digits <= w_digits_nxt;
            r_ovf    <= w_ovf_nxt;
        end
    end

    // Scan from the top digit down; a digit is blank while everything above it is zero.
    always_comb begin
        w_blank      = '0;
        w_upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_upper_zero = w_upper_zero & (r_digits[4*i +: 4] == 4'd0);
            if (i > 0) begin
                w_blank[i] = w_upper_zero;
            end
        end
    end

    always_comb begin
        out_valid = (r_state == StDone);
        bcd       = '0;
        ovf       = 1'b0;
        blank     = '0;
        if (r_state == StDone) begin
            ovf = r_ovf;
            if (r_ovf) begin
                bcd = {DIGITS{4'h9}};
            end else begin
                bcd   = r_digits;
                blank = w_blank;
            end
        end
    end

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// Scoreboard bench: three converter instances (16/5, 16/4, 8/3) against a decimal model.
module tb_seq_bin_to_bcd;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [2:0]       in_valid_a;
    logic [2:0]       in_ready_a;
    logic [2:0]       out_valid_a;
    logic [2:0]       out_ready_a;
    logic [2:0]       ovf_a;
    logic [2:0][31:0] in_data_a;
    logic [2:0][39:0] bcd_a;
    logic [2:0][9:0]  blank_a;
    logic [2:0]       fixed_rdy;
    logic [2:0]       rnd_rdy;

    int cyc    = 0;
    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [39:0] bcd;
        logic        ovf;
        logic [9:0]  blank;
        int          acc;
    } exp_t;

    exp_t exp_q[3][$];

    function automatic int unsigned w_of(int k);
        return (k == 2) ? 8 : 16;
    endfunction

    function automatic int unsigned d_of(int k);
        return (k == 0) ? 5 : ((k == 1) ? 4 : 3);
    endfunction

    function automatic void chk(string name, longint unsigned act, longint unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Decimal reference: digits by repeated division, saturate to nines past 10^D-1.
    function automatic exp_t model(int k, longint unsigned v);
        exp_t            e;
        longint unsigned lim = 1;
        longint unsigned p   = 1;
        longint unsigned t   = v;
        int              d   = int'(d_of(k));
        e = '0;
        for (int i = 0; i < d; i++) lim = lim * 10;
        if (v >= lim) begin
            e.ovf = 1'b1;
            for (int i = 0; i < d; i++) e.bcd[4*i +: 4] = 4'h9;
        end else begin
            for (int i = 0; i < d; i++) begin
                e.bcd[4*i +: 4] = 4'(t % 10);
                t = t / 10;
                if (i > 0 && v < p) e.blank[i] = 1'b1;
                p = p * 10;
            end
        end
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        for (int k = 0; k < 3; k++) begin
            out_ready_a[k] = rnd_rdy[k] ? 1'($urandom) : fixed_rdy[k];
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int unsigned WG = (g == 2) ? 8 : 16;
        localparam int unsigned DG = (g == 0) ? 5 : ((g == 1) ? 4 : 3);

        logic [4*DG-1:0] w_bcd;
        logic [DG-1:0]   w_blank;
        bit              seen = 1'b0;
        exp_t            e;

        seq_bin_to_bcd #(.W(WG), .DIGITS(DG)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid_a[g]),
            .in_ready (in_ready_a[g]),
            .in_data  (in_data_a[g][WG-1:0]),
            .out_valid(out_valid_a[g]),
            .out_ready(out_ready_a[g]),
            .bcd      (w_bcd),
            .ovf      (ovf_a[g]),
            .blank    (w_blank)
        );

        assign bcd_a[g]   = 40'(w_bcd);
        assign blank_a[g] = 10'(w_blank);

        always @(negedge clk) begin
            if (rst_n) begin
                if (out_valid_a[g]) begin
                    chk($sformatf("u%0d result_pending", g), 64'(exp_q[g].size() != 0), 1);
                    if (exp_q[g].size() != 0) begin
                        e = exp_q[g][0];
                        if (!seen) begin
                            seen = 1'b1;
                            chk($sformatf("u%0d latency", g), 64'(cyc - e.acc), 64'(WG));
                        end
                        chk($sformatf("u%0d bcd", g), bcd_a[g], e.bcd);
                        chk($sformatf("u%0d ovf", g), ovf_a[g], e.ovf);
                        chk($sformatf("u%0d blank", g), blank_a[g], e.blank);
                        chk($sformatf("u%0d in_ready_done", g), in_ready_a[g], out_ready_a[g]);
                        if (out_ready_a[g]) begin
                            void'(exp_q[g].pop_front());
                            seen = 1'b0;
                        end
                    end
                end else if (exp_q[g].size() == 0 || exp_q[g][0].acc > cyc) begin
                    chk($sformatf("u%0d idle_in_ready", g), in_ready_a[g], 1);
                    chk($sformatf("u%0d idle_bcd", g), bcd_a[g], 0);
                    chk($sformatf("u%0d idle_ovf_blank", g), {ovf_a[g], blank_a[g]}, 0);
                end else begin
                    chk($sformatf("u%0d shift_in_ready", g), in_ready_a[g], 0);
                end
            end
        end
    end

    task automatic send_w(int k, longint unsigned v, output int waited);
        exp_t e;
        waited = 0;
        in_valid_a[k] = 1'b1;
        in_data_a[k]  = 32'(v);
        forever begin
            @(negedge clk);
            if (in_ready_a[k]) break;
            waited++;
            if (waited > 400) begin
                n_cmp++;
                n_fail++;
                $display("FAIL u%0d accept_timeout: got no in_ready, want accept", k);
                @(posedge clk);
                #1;
                in_valid_a[k] = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        e     = model(k, v);
        e.acc = cyc + 1;
        exp_q[k].push_back(e);
        @(posedge clk);
        #1;
        in_valid_a[k] = 1'b0;
    endtask

    task automatic send(int k, longint unsigned v);
        int w;
        send_w(k, v, w);
    endtask

    task automatic drain(int k);
        int n = 0;
        while (exp_q[k].size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        chk($sformatf("u%0d drain_left", k), 64'(exp_q[k].size()), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(int k);
        int n = 0;
        while (!out_valid_a[k] && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("u%0d wait_valid", k), out_valid_a[k], 1);
        @(posedge clk);
        #1;
    endtask

    function automatic longint unsigned pick(int k);
        longint unsigned maxv = (64'd1 << w_of(k)) - 1;
        longint unsigned lim  = 1;
        longint unsigned v;
        for (int i = 0; i < int'(d_of(k)); i++) lim = lim * 10;
        case ($urandom_range(0, 3))
            0:       v = 64'($urandom) & maxv;
            1:       v = 64'($urandom_range(0, 99));
            2:       v = lim - 2 + 64'($urandom_range(0, 3));
            default: v = maxv;
        endcase
        return (v > maxv) ? maxv : v;
    endfunction

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n      = 1'b0;
        in_valid_a = '0;
        in_data_a  = '0;
        fixed_rdy  = 3'b111;
        rnd_rdy    = 3'b000;

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d rst_out_valid", k), out_valid_a[k], 0);
            chk($sformatf("u%0d rst_bcd", k), bcd_a[k], 0);
            chk($sformatf("u%0d rst_ovf_blank", k), {ovf_a[k], blank_a[k]}, 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_in_ready", in_ready_a, 3'b111);
        @(posedge clk);
        #1;

        send(0, 65535);
        drain(0);
        send(0, 0);
        send(0, 1200);
        drain(0);
        send(1, 9999);
        send(1, 10000);
        drain(1);
        send(2, 255);
        send(2, 7);
        drain(2);

        // Backpressure, then a new accept on the same edge the result is taken.
        fixed_rdy[0] = 1'b0;
        send(0, 65535);
        wait_valid(0);
        repeat (5) @(posedge clk);
        #1;
        fixed_rdy[0] = 1'b1;
        send_w(0, 42, w);
        chk("u0 b2b_accept_wait", 64'(w), 0);
        drain(0);

        // Reset in the eighth SHIFT cycle aborts the conversion.
        send(0, 500);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q[0].delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("u0 abort_out_valid", out_valid_a[0], 0);
        chk("u0 abort_bcd", bcd_a[0], 0);
        chk("u0 abort_in_ready", in_ready_a[0], 1);
        @(posedge clk);
        #1;
        send(0, 1234);
        drain(0);

        rnd_rdy = 3'b111;
        for (int k = 0; k < 3; k++) begin
            repeat (25) send(k, pick(k));
        end
        rnd_rdy = 3'b000;
        for (int k = 0; k < 3; k++) drain(k);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
